// File: rtl/arb_pkg.sv
// Shared constants for the 8-way round-robin arbiter: sizes, hold limit default
// and the two FSM state encodings.
package arb_pkg;

  localparam int unsigned ARB_NREQ     = 8;
  localparam int unsigned ARB_ID_W     = 3;
  localparam int unsigned ARB_MAX_HOLD = 16;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

endpackage

// File: rtl/rr_prio_enc8.sv
// Rotating priority encoder: lowest set bit of vec_i searching from ptr_i upward,
// wrapping 7->0. Purely combinational.
module rr_prio_enc8
  import arb_pkg::*;
(
  input  logic [ARB_NREQ-1:0] vec_i,
  input  logic [ARB_ID_W-1:0] ptr_i,
  output logic [ARB_ID_W-1:0] idx_o,
  output logic                valid_o
);

  logic [ARB_NREQ-1:0] rot;
  logic [ARB_ID_W-1:0] off;

  always_comb begin
    // rot[j] = vec_i[(j + ptr_i) mod 8]
    rot = ARB_NREQ'({vec_i, vec_i} >> ptr_i);
    off = '0;
    for (int unsigned i = 0; i < ARB_NREQ; i++) begin
      if (rot[ARB_NREQ-1-i]) off = ARB_ID_W'(ARB_NREQ-1-i);
    end
    idx_o   = off + ptr_i;
    valid_o = |vec_i;
  end

endmodule

// File: rtl/rr_arb8_ctrl.sv
// 8-requester round-robin arbiter with held grants. Optional forced revocation
// after MAX_HOLD cycles when the ARB_TIMEOUT_EN macro is defined.
module rr_arb8_ctrl
  import arb_pkg::*;
#(
  parameter int unsigned NREQ     = ARB_NREQ,
  parameter int unsigned MAX_HOLD = ARB_MAX_HOLD
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [NREQ-1:0]     req,
  output logic [NREQ-1:0]     gnt,
  output logic [ARB_ID_W-1:0] gnt_id,
  output logic                gnt_valid,
  output logic                gnt_timeout
);

  if (NREQ != ARB_NREQ || MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_param
    $error("rr_arb8_ctrl: NREQ must be 8 and MAX_HOLD within 2..255");
  end

  logic [0:0]          state_q, state_d;
  logic [NREQ-1:0]     gnt_q, gnt_d;
  logic [ARB_ID_W-1:0] id_q, id_d;
  logic [ARB_ID_W-1:0] ptr_q, ptr_d;
  logic [ARB_ID_W-1:0] win_id;
  logic                win_valid;
  logic                new_grant;

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD);
  logic [7:0] hold_q, hold_d;
  logic       to_q, to_d;
  logic       hold_expired;
  assign hold_expired = (hold_q >= HOLD_LIM);
`endif

  // The holder's bit is clear whenever re-arbitration happens on release, and on a
  // timeout ptr = holder+1, so the holder naturally ranks last in either case.
  rr_prio_enc8 u_enc (
    .vec_i   (req),
    .ptr_i   (ptr_q),
    .idx_o   (win_id),
    .valid_o (win_valid)
  );

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    id_d      = id_q;
    ptr_d     = ptr_q;
    new_grant = 1'b0;
`ifdef ARB_TIMEOUT_EN
    hold_d    = hold_q;
    to_d      = 1'b0;
`endif
    if (state_q == ST_IDLE) begin
      if (en && win_valid) new_grant = 1'b1;
    end else if (req[id_q]) begin
`ifdef ARB_TIMEOUT_EN
      // en=0 blocks the forced re-grant; the counter then saturates at the limit
      if (hold_expired && en) begin
        new_grant = 1'b1;
        to_d      = 1'b1;
      end else if (!hold_expired) begin
        hold_d = hold_q + 8'd1;
      end
`endif
    end else if (en && win_valid) begin
      new_grant = 1'b1;
    end else begin
      state_d = ST_IDLE;
      gnt_d   = '0;
      id_d    = '0;
    end

    if (new_grant) begin
      state_d        = ST_GRANT;
      gnt_d          = '0;
      gnt_d[win_id]  = 1'b1;
      id_d           = win_id;
      ptr_d          = win_id + 3'd1;
`ifdef ARB_TIMEOUT_EN
      hold_d         = 8'd1;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      id_q    <= '0;
      ptr_q   <= '0;
`ifdef ARB_TIMEOUT_EN
      hold_q  <= '0;
      to_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      id_q    <= id_d;
      ptr_q   <= ptr_d;
`ifdef ARB_TIMEOUT_EN
      hold_q  <= hold_d;
      to_q    <= to_d;
`endif
    end
  end

  assign gnt       = gnt_q;
  assign gnt_id    = id_q;
  assign gnt_valid = (state_q == ST_GRANT);
`ifdef ARB_TIMEOUT_EN
  assign gnt_timeout = to_q;
`else
  assign gnt_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_rr_arb8_ctrl.sv
// Bench for rr_arb8_ctrl: directed vector table, timeout sequence when
// ARB_TIMEOUT_EN is defined, then randomized traffic against a reference model.
module tb_rr_arb8_ctrl;

  localparam int unsigned TB_MAX_HOLD = 4;

  logic       clk = 1'b0;
  logic       rst, en;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] gnt_id;
  logic       gnt_valid, gnt_timeout;

  int total = 0;
  int bad   = 0;

  rr_arb8_ctrl #(.NREQ(8), .MAX_HOLD(TB_MAX_HOLD)) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .req         (req),
    .gnt         (gnt),
    .gnt_id      (gnt_id),
    .gnt_valid   (gnt_valid),
    .gnt_timeout (gnt_timeout)
  );

  always #5 clk = ~clk;

  // Reference model: current holder (-1 = none), search start, cycles held.
  int m_holder = -1;
  int m_ptr    = 0;
  int m_hold   = 0;
  bit m_to     = 1'b0;

  function automatic int pick(logic [7:0] r, int p);
    for (int k = 0; k < 8; k++) begin
      if (r[(p + k) % 8]) return (p + k) % 8;
    end
    return -1;
  endfunction

  function automatic void model_grant(logic [7:0] r);
    int w;
    w        = pick(r, m_ptr);
    m_holder = w;
    m_ptr    = (w + 1) % 8;
    m_hold   = 1;
  endfunction

  function automatic void model_update(logic r, logic e, logic [7:0] q);
    if (r) begin
      m_holder = -1; m_ptr = 0; m_hold = 0; m_to = 1'b0;
      return;
    end
    m_to = 1'b0;
    if (m_holder >= 0 && q[m_holder]) begin
`ifdef ARB_TIMEOUT_EN
      if (m_hold >= TB_MAX_HOLD && e) begin
        model_grant(q);
        m_to = 1'b1;
      end else if (m_hold < TB_MAX_HOLD) begin
        m_hold++;
      end
`endif
    end else if (e && q != 8'h00) begin
      model_grant(q);
    end else begin
      m_holder = -1;
    end
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic e, input logic [7:0] q);
    rst = r; en = e; req = q;
    @(posedge clk);
    model_update(r, e, q);
    #1;
  endtask

  task automatic check_model();
    logic [7:0] eg;
    eg = (m_holder < 0) ? 8'h00 : (8'h01 << m_holder);
    chk("rand_gnt",     int'(gnt),         int'(eg));
    chk("rand_gnt_id",  int'(gnt_id),      (m_holder < 0) ? 0 : m_holder);
    chk("rand_valid",   int'(gnt_valid),   (m_holder < 0) ? 0 : 1);
    chk("rand_timeout", int'(gnt_timeout), int'(m_to));
  endtask

  typedef struct {
    logic       r;
    logic       e;
    logic [7:0] q;
    logic [7:0] g;
    logic [2:0] id;
  } vec_t;

  vec_t tv[$];

  initial begin
    logic [7:0] rq;
    rst = 1'b1; en = 1'b0; req = 8'h00;

    // reset hold, sequential release order, no-gap handoff, wrap, en gating
    tv.push_back('{1'b1, 1'b1, 8'hFF, 8'h00, 3'd0});
    tv.push_back('{1'b1, 1'b1, 8'hFF, 8'h00, 3'd0});
    tv.push_back('{1'b0, 1'b1, 8'hFF, 8'h01, 3'd0});
    tv.push_back('{1'b0, 1'b1, 8'hFE, 8'h02, 3'd1});
    tv.push_back('{1'b0, 1'b1, 8'hFC, 8'h04, 3'd2});
    tv.push_back('{1'b0, 1'b1, 8'hF8, 8'h08, 3'd3});
    tv.push_back('{1'b0, 1'b1, 8'hF0, 8'h10, 3'd4});
    tv.push_back('{1'b0, 1'b1, 8'hE0, 8'h20, 3'd5});
    tv.push_back('{1'b0, 1'b1, 8'hC0, 8'h40, 3'd6});
    tv.push_back('{1'b0, 1'b1, 8'h80, 8'h80, 3'd7});
    tv.push_back('{1'b0, 1'b1, 8'h00, 8'h00, 3'd0});
    tv.push_back('{1'b1, 1'b1, 8'h00, 8'h00, 3'd0});
    tv.push_back('{1'b0, 1'b1, 8'h09, 8'h01, 3'd0});
    tv.push_back('{1'b0, 1'b1, 8'h08, 8'h08, 3'd3});
    tv.push_back('{1'b0, 1'b1, 8'h20, 8'h20, 3'd5});
    tv.push_back('{1'b0, 1'b1, 8'h43, 8'h40, 3'd6});
    tv.push_back('{1'b0, 1'b1, 8'h03, 8'h01, 3'd0});
    tv.push_back('{1'b0, 1'b1, 8'h02, 8'h02, 3'd1});
    tv.push_back('{1'b0, 1'b1, 8'h00, 8'h00, 3'd0});
    tv.push_back('{1'b1, 1'b0, 8'h12, 8'h00, 3'd0});
    for (int i = 0; i < 5; i++) tv.push_back('{1'b0, 1'b0, 8'h12, 8'h00, 3'd0});
    tv.push_back('{1'b0, 1'b1, 8'h12, 8'h02, 3'd1});
    tv.push_back('{1'b0, 1'b0, 8'h12, 8'h02, 3'd1});
    tv.push_back('{1'b0, 1'b0, 8'h12, 8'h02, 3'd1});
    tv.push_back('{1'b0, 1'b0, 8'h10, 8'h00, 3'd0});
    tv.push_back('{1'b0, 1'b1, 8'h10, 8'h10, 3'd4});
    tv.push_back('{1'b0, 1'b1, 8'h1F, 8'h10, 3'd4});
    tv.push_back('{1'b0, 1'b1, 8'h0F, 8'h01, 3'd0});
    tv.push_back('{1'b1, 1'b1, 8'hFF, 8'h00, 3'd0});

    foreach (tv[i]) begin
      step(tv[i].r, tv[i].e, tv[i].q);
      chk("vec_gnt",     int'(gnt),         int'(tv[i].g));
      chk("vec_gnt_id",  int'(gnt_id),      int'(tv[i].id));
      chk("vec_valid",   int'(gnt_valid),   (tv[i].g != 8'h00) ? 1 : 0);
      chk("vec_timeout", int'(gnt_timeout), 0);
    end

`ifdef ARB_TIMEOUT_EN
    // two contenders held forever: 4 cycles each, pulse on every handoff
    for (int c = 0; c < 10; c++) begin
      step(1'b0, 1'b1, 8'h03);
      chk("to_gnt_id",  int'(gnt_id),      (c >= 4 && c < 8) ? 1 : 0);
      chk("to_valid",   int'(gnt_valid),   1);
      chk("to_pulse",   int'(gnt_timeout), (c == 4 || c == 8) ? 1 : 0);
    end
    // sole requester is re-granted with a pulse
    step(1'b1, 1'b1, 8'h00);
    for (int c = 0; c < 6; c++) begin
      step(1'b0, 1'b1, 8'h04);
      chk("to_solo_gnt", int'(gnt),         8'h04);
      chk("to_solo_pls", int'(gnt_timeout), (c == 4) ? 1 : 0);
    end
    step(1'b1, 1'b1, 8'h04);
    chk("to_rst_gnt", int'(gnt), 0);
`endif

    for (int n = 0; n < 800; n++) begin
      rq = 8'($urandom);
      if ($urandom_range(0, 7) == 0) rq = 8'h00;
      if (m_holder >= 0 && $urandom_range(0, 3) != 0) rq[m_holder] = 1'b1;
      step(($urandom_range(0, 40) == 0), ($urandom_range(0, 3) != 0), rq);
      check_model();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rr_arb8_ctrl.md
RR_ARB8_CTRL -- requirements
Module: rr_arb8_ctrl

Interface
- REQ-001: Parameter NREQ, 8, number of requesters; fixed at 8, id width 3.
- REQ-002: Parameter MAX_HOLD, 16, max consecutive grant cycles per holder; only used with ARB_TIMEOUT_EN; legal range 2..255.
- REQ-003: clk  input  1  single clock; all state updates on rising edge.
- REQ-004: rst  input  1  synchronous, active-high reset.
- REQ-005: en  input  1  arbitration enable; gates new grants only.
- REQ-006: req  input  8  request vector; bit i = requester i, level-held until done.
- REQ-007: gnt  output  8  registered one-hot grant, or all zero.
- REQ-008: gnt_id  output  3  binary index of gnt bit; 0 when gnt_valid=0.
- REQ-009: gnt_valid  output  1  high when gnt is non-zero.
- REQ-010: gnt_timeout  output  1  one-cycle pulse on forced revocation; constant 0 without ARB_TIMEOUT_EN.

Function
- REQ-011: Two-state FSM, IDLE and GRANT; gnt, gnt_id, gnt_valid are registered FSM outputs.
- REQ-012: Rotating pointer ptr (3 bits); winner = first set bit of candidate vector searching ptr, ptr+1, ... wrapping 7->0.
- REQ-013: IDLE, en=1, req!=0 at edge: next cycle GRANT with winner granted; latency one clock from sampled req to gnt.
- REQ-014: On every new grant to id k, ptr <= (k+1) mod 8.
- REQ-015: GRANT: grant held unchanged while req[gnt_id]=1, regardless of other requests or en.
- REQ-016: GRANT, req[gnt_id]=0 at edge: if en=1 and other bits set, grant next winner at that same edge (no idle gap); else go IDLE, gnt=0.
- REQ-017: en=0 never revokes an existing grant; it only blocks new grants.
- REQ-018: Requests appearing/vanishing for non-holders have no effect until next arbitration.
- REQ-019: gnt never has more than one bit set; gnt_valid = |gnt at all times.

Reset
- REQ-020: rst=1 at edge: state IDLE, gnt=0, gnt_id=0, gnt_valid=0, gnt_timeout=0, ptr=0, hold counter=0.
- REQ-021: Reset mid-grant drops grant at that edge; rst has priority over every other input.
- REQ-022: First arbitration after reset considers req at the first edge with rst=0.

Configuration
- REQ-023: Macro ARB_TIMEOUT_EN defined: 8-bit hold counter counts grant cycles of current holder; cleared on each new grant.
- REQ-024: With it, once holder held MAX_HOLD cycles and req[gnt_id] still 1, next edge grants next winner (holder last by ptr), pulses gnt_timeout; if holder is sole requester, re-grants holder, counter restarts, gnt_timeout still pulses.
- REQ-025: Macro undefined: no counter logic, holds unbounded, gnt_timeout tied 0; MAX_HOLD ignored.

Structure
- REQ-026: Shared package arb_pkg holds FSM state encodings (IDLE, GRANT), NREQ, id width 3, MAX_HOLD default.
- REQ-027: One combinational sub-module rr_prio_enc8: inputs 8-bit vector and 3-bit ptr, outputs 3-bit index and valid; rotate, priority-encode lowest bit, unrotate.

Verification
- REQ-028: rst=1 two cycles with req=8'hFF -> gnt=0, gnt_valid=0, gnt_id=0; first edge after release grants id 0 one cycle later.
- REQ-029: From reset, en=1, req=8'b00001001 -> gnt=8'b00000001; drop req[0] -> same edge gnt=8'b00001000, gnt_id=3, no gap.
- REQ-030: All 8 request, each drops its bit one cycle after granted -> grant order 0,1,2,...,7, then IDLE after 7 drops.
- REQ-031: Wrap: last grant id 5 (ptr=6), req=8'b01000011 -> grants 6, then 0, then 1.
- REQ-032: en=0, req=8'h12 for 5 cycles -> no grant; en=1 -> gnt_id=1 next cycle; en=0 during grant -> grant held until req[1] drops.
- REQ-033: ARB_TIMEOUT_EN, MAX_HOLD=4, req=8'b00000011 held -> gnt id 0 4 cycles, gnt_timeout pulse, id 1 4 cycles, pulse, id 0; rst mid-grant -> gnt=0 next edge.
